// File: rtl/gamma_lut_loader.sv
// Write-side loader for the per-channel gamma LUTs: takes a table over AXI4-Stream and
// writes each entry into the masked LUTs one cycle after its handshake. It checks the table length.
module gamma_lut_loader #(
    parameter int PX_WIDTH        = 10,
    parameter int CHANNELS_AMOUNT = 3,
    parameter int TDATA_WIDTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [CHANNELS_AMOUNT-1:0] chan_mask_i,
    input  logic                       table_tvalid_i,
    output logic                       table_tready_o,
    input  logic [TDATA_WIDTH-1:0]     table_tdata_i,
    input  logic                       table_tlast_i,
    output logic [CHANNELS_AMOUNT-1:0] lut_wr_en_o,
    output logic [PX_WIDTH-1:0]        lut_wr_addr_o,
    output logic [PX_WIDTH-1:0]        lut_wr_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PX_WIDTH:0] LAST_IDX = {1'b0, {PX_WIDTH{1'b1}}};

    state_t                      state_q, state_d;
    logic [CHANNELS_AMOUNT-1:0]  mask_q, mask_d;
    logic [PX_WIDTH:0]           cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic                        tready_q, tready_d;
    logic                        busy_q, busy_d;
    logic [CHANNELS_AMOUNT-1:0]  wr_en_q, wr_en_d;
    logic [PX_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [PX_WIDTH-1:0]         wr_data_q, wr_data_d;
    logic                        hs;

    // Entry values live in the low bits only; the rest of the beat is deliberately dropped.
    generate
        if (TDATA_WIDTH > PX_WIDTH) begin : g_tdata_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^table_tdata_i[TDATA_WIDTH-1:PX_WIDTH];
        end
    endgenerate

    assign hs = table_tvalid_i & tready_q;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (chan_mask_i != '0) begin
                        mask_d  = chan_mask_i;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    wr_en_d   = mask_q;
                    wr_addr_d = cnt_q[PX_WIDTH-1:0];
                    wr_data_d = table_tdata_i[PX_WIDTH-1:0];
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        if (table_tlast_i) begin
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (table_tlast_i) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && table_tlast_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
        tready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            tready_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            tready_q  <= tready_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign table_tready_o = tready_q;
    assign lut_wr_en_o    = wr_en_q;
    assign lut_wr_addr_o  = wr_addr_q;
    assign lut_wr_data_o  = wr_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Bench for gamma_lut_loader with a 16-entry table and three channels. Writes, handshakes and
// done pulses are logged at the falling edge and compared with the table-length rules.
module tb_gamma_lut_loader;

    localparam int PXW  = 4;
    localparam int CH   = 3;
    localparam int TDW  = 16;
    localparam int NENT = 1 << PXW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CH-1:0]   mask = '0;
    logic            tvalid = 1'b0;
    logic            tready;
    logic [TDW-1:0]  tdata = '0;
    logic            tlast = 1'b0;
    logic [CH-1:0]   wr_en;
    logic [PXW-1:0]  wr_addr;
    logic [PXW-1:0]  wr_data;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    gamma_lut_loader #(.PX_WIDTH(PXW), .CHANNELS_AMOUNT(CH), .TDATA_WIDTH(TDW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .chan_mask_i(mask),
        .table_tvalid_i(tvalid), .table_tready_o(tready), .table_tdata_i(tdata),
        .table_tlast_i(tlast), .lut_wr_en_o(wr_en), .lut_wr_addr_o(wr_addr),
        .lut_wr_data_o(wr_data), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    // Falling-edge log: inputs are stable and registered outputs have settled.
    int             cyc = 0;
    int             done_cnt = 0;
    int             done_cyc = 0;
    int             bad_tready = 0;
    int             hs_q[$];
    logic [CH-1:0]  wen_q[$];
    logic [PXW-1:0] wad_q[$];
    logic [PXW-1:0] wda_q[$];
    int             wcy_q[$];
    logic [PXW-1:0] sent_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (tvalid && tready) hs_q.push_back(cyc);
            if (wr_en != '0) begin
                wen_q.push_back(wr_en);
                wad_q.push_back(wr_addr);
                wda_q.push_back(wr_data);
                wcy_q.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (!busy && tready) bad_tready <= bad_tready + 1;
        end
    end

    task automatic clear_log();
        hs_q.delete(); wen_q.delete(); wad_q.delete(); wda_q.delete(); wcy_q.delete();
        sent_q.delete();
    endtask

    task automatic pulse_start(input logic [CH-1:0] m);
        start = 1'b1; mask = m;
        @(posedge clk); #1;
        start = 1'b0; mask = '0;
    endtask

    // Sends n beats; tlast on beat last_idx (-1: never). Value is descending or random.
    task automatic send_beats(input int n, input int last_idx, input bit gaps, input bit rnd);
        for (int i = 0; i < n; i++) begin
            bit hs_seen;
            int guard;
            logic [PXW-1:0] v;
            if (gaps) begin
                tvalid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            v = rnd ? PXW'($urandom_range(0, NENT-1)) : PXW'(NENT - 1 - i);
            tvalid = 1'b1;
            tdata  = {TDW'($urandom) >> PXW, v};
            tlast  = (i == last_idx);
            sent_q.push_back(v);
            hs_seen = 1'b0;
            guard = 0;
            while (!hs_seen && guard < 100) begin
                @(negedge clk); hs_seen = tready;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs_seen) begin
                checks++; errors++;
                $display("FAIL handshake_timeout beat=%0d got no tready need tready=1", i);
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int guard = 0;
        while (done_cnt == base && guard < 60) begin @(posedge clk); #1; guard++; end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({tready, wr_en, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b need 0", {tready, wr_en, busy, done, err});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (tready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got tready=%b busy=%b need 0 0", tready, busy);
        end
        $display("reset: tready=%b busy=%b err=%b", tready, busy, err);
    endtask

    // Full 16-entry table, optionally with random tvalid gaps.
    task automatic test_full_table(input logic [CH-1:0] m, input bit gaps);
        int base = done_cnt;
        int bt = bad_tready;
        clear_log();
        pulse_start(m);
        send_beats(NENT, NENT - 1, gaps, 1'b0);
        wait_done(base);
        $display("full: mask=%b gaps=%0b hs=%0d writes=%0d err=%b", m, gaps, hs_q.size(), wen_q.size(), err);
        checks++;
        if (hs_q.size() != NENT || wen_q.size() != NENT) begin
            errors++;
            $display("FAIL full_count got hs=%0d wr=%0d need %0d", hs_q.size(), wen_q.size(), NENT);
        end else begin
            for (int i = 0; i < NENT; i++) begin
                checks++;
                if (wen_q[i] !== m || wad_q[i] !== PXW'(i) || wda_q[i] !== PXW'(NENT - 1 - i)
                    || wcy_q[i] != hs_q[i] + 1) begin
                    errors++;
                    $display("FAIL full_write i=%0d got en=%b a=%0d d=%0d lat=%0d need en=%b a=%0d d=%0d lat=1",
                             i, wen_q[i], wad_q[i], wda_q[i], wcy_q[i] - hs_q[i], m, i, NENT - 1 - i);
                end
            end
            checks++;
            if (done_cyc != hs_q[NENT-1] + 1) begin
                errors++;
                $display("FAIL full_done_time got %0d need %0d", done_cyc, hs_q[NENT-1] + 1);
            end
        end
        checks++;
        if (done_cnt - base != 1 || err !== 1'b0 || busy !== 1'b0 || bad_tready != bt) begin
            errors++;
            $display("FAIL full_status got done=%0d err=%b busy=%b idle_tready=%0d need 1 0 0 0",
                     done_cnt - base, err, busy, bad_tready - bt);
        end
    endtask

    // Tables of the wrong length: n beats with tlast on the final one.
    task automatic test_bad_length(input logic [CH-1:0] m, input int n);
        int base = done_cnt;
        int nw = (n < NENT) ? n : NENT;
        clear_log();
        pulse_start(m);
        send_beats(n, n - 1, 1'b1, 1'b1);
        wait_done(base);
        $display("length: mask=%b beats=%0d hs=%0d writes=%0d err=%b", m, n, hs_q.size(), wen_q.size(), err);
        checks++;
        if (hs_q.size() != n || wen_q.size() != nw) begin
            errors++;
            $display("FAIL len_count got hs=%0d wr=%0d need %0d %0d", hs_q.size(), wen_q.size(), n, nw);
        end else begin
            for (int i = 0; i < nw; i++) begin
                checks++;
                if (wen_q[i] !== m || wad_q[i] !== PXW'(i) || wda_q[i] !== sent_q[i]
                    || wcy_q[i] != hs_q[i] + 1) begin
                    errors++;
                    $display("FAIL len_write i=%0d got en=%b a=%0d d=%0d need en=%b a=%0d d=%0d",
                             i, wen_q[i], wad_q[i], wda_q[i], m, i, sent_q[i]);
                end
            end
            checks++;
            if (done_cyc != hs_q[n-1] + 1) begin
                errors++;
                $display("FAIL len_done_time got %0d need %0d", done_cyc, hs_q[n-1] + 1);
            end
        end
        checks++;
        if (done_cnt - base != 1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len_status got done=%0d err=%b busy=%b need 1 1 0", done_cnt - base, err, busy);
        end
    endtask

    task automatic test_mask_zero();
        int base = done_cnt;
        int bt = bad_tready;
        clear_log();
        tvalid = 1'b1; tdata = '0;
        pulse_start('0);
        repeat (4) begin @(posedge clk); #1; end
        tvalid = 1'b0;
        $display("mask0: hs=%0d writes=%0d done=%0d err=%b", hs_q.size(), wen_q.size(), done_cnt - base, err);
        checks++;
        if (hs_q.size() != 0 || wen_q.size() != 0 || done_cnt - base != 1 || err !== 1'b1
            || busy !== 1'b0 || bad_tready != bt) begin
            errors++;
            $display("FAIL mask0 got hs=%0d wr=%0d done=%0d err=%b busy=%b need 0 0 1 1 0",
                     hs_q.size(), wen_q.size(), done_cnt - base, err, busy);
        end
        pulse_start(3'b011);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mask0_clear got err=%b busy=%b need 0 1", err, busy);
        end
        send_beats(NENT, NENT - 1, 1'b0, 1'b1);
        wait_done(base + 1);
        checks++;
        if (wen_q.size() != NENT || err !== 1'b0) begin
            errors++;
            $display("FAIL mask0_reload got wr=%0d err=%b need %0d 0", wen_q.size(), err, NENT);
        end
    endtask

    task automatic test_reset_midload();
        int base = done_cnt;
        clear_log();
        pulse_start(3'b110);
        send_beats(7, -1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        $display("midreset: hs=%0d writes=%0d", hs_q.size(), wen_q.size());
        checks++;
        if ({tready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %b need 0", {tready, wr_en, wr_addr, wr_data, busy, done, err});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (tready !== 1'b0 || busy !== 1'b0 || done_cnt != base || hs_q.size() != 7) begin
            errors++;
            $display("FAIL midreset_idle got tready=%b busy=%b done=%0d hs=%0d need 0 0 0 7",
                     tready, busy, done_cnt - base, hs_q.size());
        end
        test_full_table(3'b111, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_table(3'b101, 1'b0);
        test_full_table(3'b101, 1'b1);
        test_mask_zero();
        test_bad_length(3'b010, 10);
        test_bad_length(3'b101, 20);
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running need finished");
        $fatal(1);
    end

endmodule
